// File: rtl/ack_retransmit_buffer.sv
// Tracks first-transmission flits awaiting ACK; frees them on ACK, otherwise offers them for
// retransmission after a timeout and drops them once the retry budget is spent.
module ack_retransmit_buffer #(
  parameter int unsigned FLIT_W    = 128,
  parameter int unsigned TAG_W     = 8,
  parameter int unsigned TAG_LSB   = 0,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned TIMEOUT   = 1024,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic              nocclk,
  input  logic              rst,
  input  logic [FLIT_W-1:0] tx_flit,
  input  logic              tx_valid,
  input  logic              tx_ready,
  input  logic              tx_need_ack,
  input  logic [FLIT_W-1:0] ack_flit,
  input  logic              ack_valid,
  output logic [FLIT_W-1:0] retx_flit,
  output logic              retx_valid,
  input  logic              retx_ready,
  output logic              full,
  output logic              overflow,
  output logic              drop_valid,
  output logic [TAG_W-1:0]  drop_tag
);

  localparam int unsigned TimerW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int unsigned IdxW   = $clog2(DEPTH);
  localparam logic [TimerW-1:0] TimerMax = TimerW'(TIMEOUT - 1);
  localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRY);

  typedef enum logic [0:0] {StIdle, StOffer} state_e;

  logic [DEPTH-1:0]  valid_q, valid_d, pending_q, pending_d, in_flight_q, in_flight_d;
  logic [FLIT_W-1:0] flit_q [DEPTH];
  logic [FLIT_W-1:0] flit_d [DEPTH];
  logic [TimerW-1:0] timer_q [DEPTH];
  logic [TimerW-1:0] timer_d [DEPTH];
  logic [RetryW-1:0] retry_q [DEPTH];
  logic [RetryW-1:0] retry_d [DEPTH];

  state_e            state_q, state_d;
  logic [IdxW-1:0]   src_q, src_d;
  logic [FLIT_W-1:0] retx_flit_q, retx_flit_d;
  logic              retx_valid_q, retx_valid_d;
  logic              full_q, full_d;
  logic              overflow_q, overflow_d;
  logic              drop_valid_q, drop_valid_d;
  logic [TAG_W-1:0]  drop_tag_q, drop_tag_d;

  logic            cap_found, ack_found, pend_found, drop_found;
  logic [IdxW-1:0] cap_idx, ack_idx, pend_idx, drop_idx;
  logic [TAG_W-1:0] ack_tag;
  logic            capture, ack_hit;
  logic            unused_ack_bits;

  function automatic logic [TAG_W-1:0] tag_of(input logic [FLIT_W-1:0] f);
    return f[TAG_LSB +: TAG_W];
  endfunction

  assign ack_tag         = tag_of(ack_flit);
  assign unused_ack_bits = ^ack_flit;
  assign capture         = tx_valid && tx_ready && tx_need_ack;
  assign ack_hit         = ack_valid && ack_found;

  // All searches look at pre-edge state, so a slot freed this cycle is not reusable until next.
  always_comb begin
    cap_found  = 1'b0;
    cap_idx    = '0;
    ack_found  = 1'b0;
    ack_idx    = '0;
    pend_found = 1'b0;
    pend_idx   = '0;
    drop_found = 1'b0;
    drop_idx   = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (!cap_found && !valid_q[i]) begin
        cap_found = 1'b1;
        cap_idx   = IdxW'(i);
      end
      if (!ack_found && valid_q[i] && (tag_of(flit_q[i]) == ack_tag)) begin
        ack_found = 1'b1;
        ack_idx   = IdxW'(i);
      end
      if (!pend_found && valid_q[i] && pending_q[i]) begin
        pend_found = 1'b1;
        pend_idx   = IdxW'(i);
      end
      if (!drop_found && valid_q[i] && !pending_q[i] && !in_flight_q[i] &&
          (timer_q[i] == TimerMax) && (retry_q[i] == RetryMax)) begin
        drop_found = 1'b1;
        drop_idx   = IdxW'(i);
      end
    end
  end

  always_comb begin
    valid_d      = valid_q;
    pending_d    = pending_q;
    in_flight_d  = in_flight_q;
    flit_d       = flit_q;
    timer_d      = timer_q;
    retry_d      = retry_q;
    state_d      = state_q;
    src_d        = src_q;
    retx_flit_d  = retx_flit_q;
    retx_valid_d = retx_valid_q;
    overflow_d   = 1'b0;
    drop_valid_d = 1'b0;
    drop_tag_d   = drop_tag_q;

    // Timers saturate at TIMEOUT-1; an exhausted entry waits there until the drop logic takes it.
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (valid_q[i] && !pending_q[i] && !in_flight_q[i]) begin
        if (timer_q[i] != TimerMax) begin
          timer_d[i] = timer_q[i] + 1'b1;
        end else if (retry_q[i] < RetryMax) begin
          pending_d[i] = 1'b1;
        end
      end
    end

    if (drop_found && !(ack_hit && (ack_idx == drop_idx))) begin
      valid_d[drop_idx] = 1'b0;
      drop_valid_d      = 1'b1;
      drop_tag_d        = tag_of(flit_q[drop_idx]);
    end

    unique case (state_q)
      StIdle: begin
        if (pend_found) begin
          retx_flit_d           = flit_q[pend_idx];
          retx_valid_d          = 1'b1;
          pending_d[pend_idx]   = 1'b0;
          in_flight_d[pend_idx] = 1'b1;
          retry_d[pend_idx]     = retry_q[pend_idx] + 1'b1;
          src_d                 = pend_idx;
          state_d               = StOffer;
        end
      end
      StOffer: begin
        if (retx_ready) begin
          retx_valid_d = 1'b0;
          state_d      = StIdle;
          // in_flight is cleared on any free, so a freed or reused slot is left alone here.
          if (in_flight_q[src_q]) begin
            in_flight_d[src_q] = 1'b0;
            timer_d[src_q]     = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (ack_hit) begin
      valid_d[ack_idx]     = 1'b0;
      pending_d[ack_idx]   = 1'b0;
      in_flight_d[ack_idx] = 1'b0;
    end

    if (capture) begin
      if (cap_found) begin
        valid_d[cap_idx]     = 1'b1;
        pending_d[cap_idx]   = 1'b0;
        in_flight_d[cap_idx] = 1'b0;
        flit_d[cap_idx]      = tx_flit;
        timer_d[cap_idx]     = '0;
        retry_d[cap_idx]     = '0;
      end else begin
        overflow_d = 1'b1;
      end
    end

    full_d = &valid_d;
  end

  always_ff @(posedge nocclk) begin
    if (rst) begin
      valid_q      <= '0;
      pending_q    <= '0;
      in_flight_q  <= '0;
      flit_q       <= '{default: '0};
      timer_q      <= '{default: '0};
      retry_q      <= '{default: '0};
      state_q      <= StIdle;
      src_q        <= '0;
      retx_flit_q  <= '0;
      retx_valid_q <= 1'b0;
      full_q       <= 1'b0;
      overflow_q   <= 1'b0;
      drop_valid_q <= 1'b0;
      drop_tag_q   <= '0;
    end else begin
      valid_q      <= valid_d;
      pending_q    <= pending_d;
      in_flight_q  <= in_flight_d;
      flit_q       <= flit_d;
      timer_q      <= timer_d;
      retry_q      <= retry_d;
      state_q      <= state_d;
      src_q        <= src_d;
      retx_flit_q  <= retx_flit_d;
      retx_valid_q <= retx_valid_d;
      full_q       <= full_d;
      overflow_q   <= overflow_d;
      drop_valid_q <= drop_valid_d;
      drop_tag_q   <= drop_tag_d;
    end
  end

  assign retx_flit  = retx_flit_q;
  assign retx_valid = retx_valid_q;
  assign full       = full_q;
  assign overflow   = overflow_q;
  assign drop_valid = drop_valid_q;
  assign drop_tag   = drop_tag_q;

endmodule

// File: tb/tb_ack_retransmit_buffer.sv
// Self-checking bench for ack_retransmit_buffer: table of capture/ACK vectors for full/overflow,
// plus timed sequences whose retransmissions and drops are checked against a scoreboard queue.
module tb_ack_retransmit_buffer;

  localparam int unsigned FW = 32;

  logic          nocclk = 1'b0;
  logic          rst = 1'b1;
  logic [FW-1:0] tx_flit = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready = 1'b0;
  logic          tx_need_ack = 1'b0;
  logic [FW-1:0] ack_flit = '0;
  logic          ack_valid = 1'b0;
  logic [FW-1:0] retx_flit;
  logic          retx_valid;
  logic          retx_ready = 1'b0;
  logic          full;
  logic          overflow;
  logic          drop_valid;
  logic [7:0]    drop_tag;

  ack_retransmit_buffer #(
    .FLIT_W   (FW),
    .TAG_W    (8),
    .TAG_LSB  (0),
    .DEPTH    (4),
    .TIMEOUT  (16),
    .MAX_RETRY(3)
  ) dut (
    .nocclk     (nocclk),
    .rst        (rst),
    .tx_flit    (tx_flit),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_need_ack(tx_need_ack),
    .ack_flit   (ack_flit),
    .ack_valid  (ack_valid),
    .retx_flit  (retx_flit),
    .retx_valid (retx_valid),
    .retx_ready (retx_ready),
    .full       (full),
    .overflow   (overflow),
    .drop_valid (drop_valid),
    .drop_tag   (drop_tag)
  );

  always #5 nocclk = ~nocclk;

  int tests = 0;
  int fails = 0;
  int edge_cnt = 0;
  always @(posedge nocclk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    int         edge_no;
    bit         is_drop;
    logic [7:0] tag;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    bit         txv;
    bit         txr;
    bit         need;
    bit         ackv;
    logic [7:0] ttag;
    logic [7:0] atag;
    bit         efull;
    bit         eov;
  } vec_t;
  vec_t vecs[19];

  function automatic logic [FW-1:0] make_flit(input logic [7:0] t);
    return {t ^ 8'hC3, 8'h5A, ~t, t};
  endfunction

  function automatic logic [FW-1:0] make_ack(input logic [7:0] t);
    return {16'hACC0, 8'h00, t};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic observe(input bit is_drop, input logic [7:0] tag, input logic [FW-1:0] flit);
    exp_t e;
    tests++;
    if (sbq.size() == 0) begin
      fails++;
      $display("FAIL unexpected_%s: got tag %0h at edge %0d, expected no event",
               is_drop ? "drop" : "retx", tag, edge_cnt);
    end else begin
      e = sbq.pop_front();
      if (e.is_drop != is_drop || e.tag !== tag || e.edge_no != edge_cnt ||
          (!is_drop && flit !== make_flit(e.tag))) begin
        fails++;
        $display("FAIL sb_event: got %s tag %0h flit %0h edge %0d, expected %s tag %0h edge %0d",
                 is_drop ? "drop" : "retx", tag, flit, edge_cnt,
                 e.is_drop ? "drop" : "retx", e.tag, e.edge_no);
      end
    end
  endtask

  // Offer/drop monitor, sampled on the falling edge.
  logic          prev_valid = 1'b0;
  logic          prev_hs = 1'b0;
  logic [FW-1:0] prev_flit = '0;
  always @(negedge nocclk) begin
    if (rst) begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
    end else begin
      if (drop_valid) observe(1'b1, drop_tag, '0);
      if (prev_valid && !prev_hs) begin
        chk("retx_hold_valid", retx_valid, 1);
        chk("retx_hold_flit", retx_flit, prev_flit);
      end else if (retx_valid) begin
        observe(1'b0, retx_flit[7:0], retx_flit);
      end
      prev_valid = retx_valid;
      prev_hs    = retx_valid && retx_ready;
      prev_flit  = retx_flit;
    end
  end

  task automatic tick();
    @(posedge nocclk);
    #1;
  endtask

  task automatic wait_until(input int n);
    while (edge_cnt < n) tick();
  endtask

  task automatic push(input int n, input bit d, input logic [7:0] t);
    sbq.push_back('{n, d, t});
  endtask

  task automatic sb_empty(input string name);
    tests++;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL %s: got %0d pending expected events, expected 0", name, sbq.size());
    end
    sbq.delete();
  endtask

  task automatic cap(input logic [7:0] t, output int e);
    tx_flit     = make_flit(t);
    tx_valid    = 1'b1;
    tx_ready    = 1'b1;
    tx_need_ack = 1'b1;
    tick();
    e           = edge_cnt;
    tx_valid    = 1'b0;
    tx_ready    = 1'b0;
    tx_need_ack = 1'b0;
  endtask

  task automatic ack(input logic [7:0] t);
    ack_flit  = make_ack(t);
    ack_valid = 1'b1;
    tick();
    ack_valid = 1'b0;
  endtask

  initial begin
    int t0;
    int e;

    vecs[0]  = '{1, 1, 1, 0, 8'h01, 8'h00, 0, 0};
    vecs[1]  = '{1, 1, 1, 0, 8'h02, 8'h00, 0, 0};
    vecs[2]  = '{1, 1, 1, 0, 8'h03, 8'h00, 0, 0};
    vecs[3]  = '{1, 1, 1, 0, 8'h04, 8'h00, 1, 0};
    vecs[4]  = '{1, 1, 1, 0, 8'h09, 8'h00, 1, 1};  // overflow, not stored
    vecs[5]  = '{0, 0, 0, 0, 8'h00, 8'h00, 1, 0};
    vecs[6]  = '{0, 0, 0, 1, 8'h00, 8'h02, 0, 0};
    vecs[7]  = '{1, 1, 0, 0, 8'h06, 8'h00, 0, 0};  // no ACK needed
    vecs[8]  = '{1, 0, 1, 0, 8'h06, 8'h00, 0, 0};  // no handshake
    vecs[9]  = '{1, 1, 1, 0, 8'h09, 8'h00, 1, 0};
    vecs[10] = '{0, 0, 0, 1, 8'h00, 8'h09, 0, 0};
    vecs[11] = '{0, 0, 0, 1, 8'h00, 8'h09, 0, 0};  // no match
    vecs[12] = '{1, 1, 1, 0, 8'h07, 8'h00, 1, 0};
    vecs[13] = '{1, 1, 1, 1, 8'h08, 8'h07, 0, 1};  // freed slot not reusable same cycle
    vecs[14] = '{1, 1, 1, 0, 8'h08, 8'h00, 1, 0};
    vecs[15] = '{0, 0, 0, 1, 8'h00, 8'h01, 0, 0};
    vecs[16] = '{0, 0, 0, 1, 8'h00, 8'h03, 0, 0};
    vecs[17] = '{0, 0, 0, 1, 8'h00, 8'h04, 0, 0};
    vecs[18] = '{0, 0, 0, 1, 8'h00, 8'h08, 0, 0};

    repeat (3) tick();
    rst = 1'b0;
    chk("rst_retx_valid", retx_valid, 0);
    chk("rst_retx_flit", retx_flit, 0);
    chk("rst_full", full, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_drop_valid", drop_valid, 0);
    chk("rst_drop_tag", drop_tag, 0);

    // Capture then ACK before timeout: nothing retransmitted.
    retx_ready = 1'b1;
    cap(8'h05, t0);
    wait_until(t0 + 9);
    ack(8'h05);
    chk("ack_full", full, 0);
    repeat (40) tick();
    chk("ack_full_late", full, 0);
    sb_empty("ack_no_retx");

    for (int i = 0; i < 19; i++) begin
      tx_flit     = make_flit(vecs[i].ttag);
      tx_valid    = vecs[i].txv;
      tx_ready    = vecs[i].txr;
      tx_need_ack = vecs[i].need;
      ack_flit    = make_ack(vecs[i].atag);
      ack_valid   = vecs[i].ackv;
      tick();
      chk($sformatf("vec%0d_full", i), full, vecs[i].efull);
      chk($sformatf("vec%0d_overflow", i), overflow, vecs[i].eov);
    end
    tx_valid    = 1'b0;
    tx_ready    = 1'b0;
    tx_need_ack = 1'b0;
    ack_valid   = 1'b0;
    repeat (30) tick();
    sb_empty("table_no_retx");

    // Full timeout ladder: three retransmissions then a drop.
    retx_ready = 1'b1;
    cap(8'h01, t0);
    push(t0 + 17, 1'b0, 8'h01);
    push(t0 + 35, 1'b0, 8'h01);
    push(t0 + 53, 1'b0, 8'h01);
    push(t0 + 70, 1'b1, 8'h01);
    wait_until(t0 + 90);
    sb_empty("timeout_ladder");
    chk("timeout_full", full, 0);

    // Back-to-back expiries with stalled ready, then ACK during a stale offer.
    retx_ready = 1'b0;
    cap(8'h03, t0);
    cap(8'h04, e);
    push(t0 + 17, 1'b0, 8'h03);
    push(t0 + 24, 1'b0, 8'h04);
    push(t0 + 40, 1'b0, 8'h03);
    push(t0 + 45, 1'b0, 8'h04);
    chk("second_cap_edge", e, t0 + 1);
    wait_until(t0 + 22);
    retx_ready = 1'b1;
    wait_until(t0 + 25);
    retx_ready = 1'b0;
    wait_until(t0 + 40);
    ack(8'h03);
    wait_until(t0 + 43);
    retx_ready = 1'b1;
    wait_until(t0 + 50);
    ack(8'h04);
    wait_until(t0 + 130);
    sb_empty("stall_and_stale");

    // Reset while an offer is outstanding.
    retx_ready = 1'b0;
    cap(8'h11, t0);
    cap(8'h12, e);
    cap(8'h13, e);
    push(t0 + 17, 1'b0, 8'h11);
    wait_until(t0 + 18);
    chk("pre_rst_retx_valid", retx_valid, 1);
    rst = 1'b1;
    tick();
    chk("mid_rst_retx_valid", retx_valid, 0);
    chk("mid_rst_retx_flit", retx_flit, 0);
    chk("mid_rst_full", full, 0);
    tick();
    rst = 1'b0;
    ack(8'h11);
    ack(8'h12);
    ack(8'h13);
    repeat (40) tick();
    sb_empty("after_rst");
    chk("after_rst_full", full, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
